// File: rtl/mips8_controller.sv
// Multicycle control FSM for the MIPS8 8-bit datapath (two-byte fetch, 4-bit opcode).
// Optional MIPS8_MEM_WAIT_EN adds mem_ready handshaking on memory states.
module mips8_controller #(
  parameter logic [2:0] ALU_ADD = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        CF,
  input  logic        VF,
  input  logic        ZF,
  input  logic        SF,
`ifdef MIPS8_MEM_WAIT_EN
  input  logic        mem_ready,
`endif
  output logic        enPC,
  output logic        enData,
  output logic        enFlags,
  output logic        we,
  output logic [1:0]  enIR,
  output logic [1:0]  addrSrc,
  output logic        PCsrc,
  output logic        JR,
  output logic [2:0]  regSrc,
  output logic [1:0]  regDst,
  output logic [1:0]  srcA,
  output logic [1:0]  srcB,
  output logic [2:0]  aluop,
  output logic        cin,
  output logic        memwe,
  output logic        halted
);

  typedef enum logic [3:0] {
    FETCH_HI, FETCH_LO, DECODE, EXEC, ALU_WB,
    MEM_RD, LD_WB, MEM_WR, HALT
  } state_e;

  typedef struct packed {
    logic       en_pc;
    logic       en_data;
    logic       en_flags;
    logic       we;
    logic [1:0] en_ir;
    logic [1:0] addr_src;
    logic       pc_src;
    logic       jr;
    logic [2:0] reg_src;
    logic [1:0] reg_dst;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] aluop;
    logic       cin;
    logic       memwe;
    logic       halted;
  } ctl_t;

  state_e     state_q, state_d;
  ctl_t       c, cg;
  logic [3:0] op;
  logic [1:0] mem_addr;
  logic       rdy;
  logic       unused_ok;

`ifdef MIPS8_MEM_WAIT_EN
  assign rdy = mem_ready;
`else
  assign rdy = 1'b1;
`endif

  assign op        = instr[15:12];
  assign unused_ok = ^{VF, instr[11:4]};
  // LDR/STR address through rb, LD/ST through the immediate
  assign mem_addr  = (op == 4'h5 || op == 4'h6) ? 2'b01 : 2'b10;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FETCH_HI;
    else      state_q <= state_d;
  end

  always_comb begin
    c       = '0;
    state_d = state_q;
    unique case (state_q)
      FETCH_HI, FETCH_LO: begin
        c.addr_src = 2'b00;
        c.src_a    = 2'b01;
        c.src_b    = 2'b01;
        c.aluop    = ALU_ADD;
        c.en_pc    = rdy;
        if (rdy) begin
          c.en_ir = (state_q == FETCH_HI) ? 2'b10 : 2'b01;
          state_d = (state_q == FETCH_HI) ? FETCH_LO : DECODE;
        end
      end
      DECODE: begin
        state_d = FETCH_HI;
        unique case (op)
          4'h0, 4'h1: state_d = EXEC;
          4'h2: begin
            c.we      = 1'b1;
            c.reg_src = 3'b011;
          end
          4'h7: begin
            c.we      = 1'b1;
            c.reg_src = 3'b010;
          end
          4'h3, 4'h5: state_d = MEM_RD;
          4'h4, 4'h6: state_d = MEM_WR;
          4'h8: begin
            c.pc_src = 1'b1;
            c.en_pc  = 1'b1;
          end
          4'h9, 4'hA, 4'hB, 4'hC: begin
            c.pc_src = 1'b1;
            unique case (op)
              4'h9:    c.en_pc = ZF;
              4'hA:    c.en_pc = ~ZF;
              4'hB:    c.en_pc = CF;
              default: c.en_pc = SF;
            endcase
          end
          4'hD: begin
            c.we      = 1'b1;
            c.reg_dst = 2'b01;
            c.reg_src = 3'b100;
            c.pc_src  = 1'b1;
            c.en_pc   = 1'b1;
          end
          4'hE: begin
            c.jr    = 1'b1;
            c.en_pc = 1'b1;
          end
          4'hF: state_d = HALT;
        endcase
      end
      EXEC: begin
        c.src_a    = 2'b00;
        c.en_flags = 1'b1;
        if (op == 4'h0) begin
          c.src_b = 2'b00;
          c.aluop = instr[2:0];
          c.cin   = instr[3];
        end else begin
          c.src_b = 2'b10;
          c.aluop = ALU_ADD;
        end
        state_d = ALU_WB;
      end
      ALU_WB: begin
        c.reg_src = 3'b000;
        c.we      = 1'b1;
        state_d   = FETCH_HI;
      end
      MEM_RD: begin
        c.addr_src = mem_addr;
        c.en_data  = rdy;
        if (rdy) state_d = LD_WB;
      end
      LD_WB: begin
        c.reg_src = 3'b001;
        c.we      = 1'b1;
        state_d   = FETCH_HI;
      end
      MEM_WR: begin
        // strobe held for the whole access so the address stays stable
        c.addr_src = mem_addr;
        c.memwe    = 1'b1;
        if (rdy) state_d = FETCH_HI;
      end
      HALT: c.halted = 1'b1;
      default: state_d = FETCH_HI;
    endcase
  end

  assign cg      = rst ? c : '0;
  assign enPC    = cg.en_pc;
  assign enData  = cg.en_data;
  assign enFlags = cg.en_flags;
  assign we      = cg.we;
  assign enIR    = cg.en_ir;
  assign addrSrc = cg.addr_src;
  assign PCsrc   = cg.pc_src;
  assign JR      = cg.jr;
  assign regSrc  = cg.reg_src;
  assign regDst  = cg.reg_dst;
  assign srcA    = cg.src_a;
  assign srcB    = cg.src_b;
  assign aluop   = cg.aluop;
  assign cin     = cg.cin;
  assign memwe   = cg.memwe;
  assign halted  = cg.halted;

endmodule

// File: tb/tb_mips8_controller.sv
// Directed bench for mips8_controller: walks every opcode state by state.
// Control outputs are packed and compared against hand-built vectors.
module tb_mips8_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instr = '0;
  logic        CF = 1'b0, VF = 1'b0, ZF = 1'b0, SF = 1'b0;
  logic        mem_ready = 1'b1;
  logic        enPC, enData, enFlags, we, PCsrc, JR, cin, memwe, halted;
  logic [1:0]  enIR, addrSrc, regDst, srcA, srcB;
  logic [2:0]  regSrc, aluop;
  logic [24:0] got;
  int          total = 0;
  int          bad = 0;

  mips8_controller dut (
    .clk(clk), .rst(rst), .instr(instr),
    .CF(CF), .VF(VF), .ZF(ZF), .SF(SF),
`ifdef MIPS8_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .enPC(enPC), .enData(enData), .enFlags(enFlags), .we(we),
    .enIR(enIR), .addrSrc(addrSrc), .PCsrc(PCsrc), .JR(JR),
    .regSrc(regSrc), .regDst(regDst), .srcA(srcA), .srcB(srcB),
    .aluop(aluop), .cin(cin), .memwe(memwe), .halted(halted)
  );

  always #5 clk = ~clk;

  assign got = {enPC, enData, enFlags, we, enIR, addrSrc, PCsrc, JR,
                regSrc, regDst, srcA, srcB, aluop, cin, memwe, halted};

  function automatic logic [24:0] mk(
    input logic pc, input logic dat, input logic fl, input logic w,
    input logic [1:0] ir, input logic [1:0] ad,
    input logic ps, input logic j,
    input logic [2:0] rs, input logic [1:0] rd,
    input logic [1:0] sa, input logic [1:0] sb,
    input logic [2:0] op, input logic ci,
    input logic mw, input logic h);
    return {pc, dat, fl, w, ir, ad, ps, j, rs, rd, sa, sb, op, ci, mw, h};
  endfunction

  logic [24:0] FH, FL, Z;

  task automatic chk(input string tag, input logic [24:0] g,
                     input logic [24:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, g, e);
    end
  endtask

  task automatic step(input string tag, input logic [24:0] e);
    chk(tag, got, e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] iv);
    step("fetch_hi", FH);
    instr = iv;
    step("fetch_lo", FL);
  endtask

  initial begin
    FH = mk(1,0,0,0,2'b10,2'b00,0,0,3'd0,2'd0,2'b01,2'b01,3'd0,0,0,0);
    FL = mk(1,0,0,0,2'b01,2'b00,0,0,3'd0,2'd0,2'b01,2'b01,3'd0,0,0,0);
    Z  = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_low", got, Z);
    rst = 1'b1;
    #1;

`ifdef MIPS8_MEM_WAIT_EN
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      step("wait_fh", mk(0,0,0,0,2'b00,2'b00,0,0,3'd0,2'd0,
                         2'b01,2'b01,3'd0,0,0,0));
    mem_ready = 1'b1;
`endif

    // LI r1,5 ; LI r2,3
    fetch(16'h2205);
    step("li_dec", mk(0,0,0,1,2'b00,2'b00,0,0,3'b011,2'd0,
                      2'b00,2'b00,3'd0,0,0,0));
    fetch(16'h2403);
    step("li2_dec", mk(0,0,0,1,2'b00,2'b00,0,0,3'b011,2'd0,
                       2'b00,2'b00,3'd0,0,0,0));

    // ALU r1,r2 fn=001 cin=1
    fetch(16'h0289);
    step("alu_dec", Z);
    step("alu_exec", mk(0,0,1,0,2'b00,2'b00,0,0,3'd0,2'd0,
                        2'b00,2'b00,3'b001,1,0,0));
    step("alu_wb", mk(0,0,0,1,2'b00,2'b00,0,0,3'd0,2'd0,
                      2'b00,2'b00,3'd0,0,0,0));

    // branches taken and not taken
    ZF = 1'b1;
    fetch(16'h9040);
    step("bz_taken", mk(1,0,0,0,2'b00,2'b00,1,0,3'd0,2'd0,
                        2'b00,2'b00,3'd0,0,0,0));
    ZF = 1'b0;
    fetch(16'h9040);
    step("bz_fall", mk(0,0,0,0,2'b00,2'b00,1,0,3'd0,2'd0,
                       2'b00,2'b00,3'd0,0,0,0));
    fetch(16'hA040);
    step("bnz_taken", mk(1,0,0,0,2'b00,2'b00,1,0,3'd0,2'd0,
                         2'b00,2'b00,3'd0,0,0,0));
    CF = 1'b1;
    fetch(16'hB040);
    step("bc_taken", mk(1,0,0,0,2'b00,2'b00,1,0,3'd0,2'd0,
                        2'b00,2'b00,3'd0,0,0,0));
    CF = 1'b0;
    SF = 1'b0;
    fetch(16'hC040);
    step("bn_fall", mk(0,0,0,0,2'b00,2'b00,1,0,3'd0,2'd0,
                       2'b00,2'b00,3'd0,0,0,0));

    // ADDI with instr[3] set: cin must stay 0
    fetch(16'h120F);
    step("addi_dec", Z);
    step("addi_exec", mk(0,0,1,0,2'b00,2'b00,0,0,3'd0,2'd0,
                         2'b00,2'b10,3'd0,0,0,0));
    step("addi_wb", mk(0,0,0,1,2'b00,2'b00,0,0,3'd0,2'd0,
                       2'b00,2'b00,3'd0,0,0,0));

    // ST r1,[80] ; LD r3,[80] ; STR ; LDR
    fetch(16'h4280);
    step("st_dec", Z);
    step("st_wr", mk(0,0,0,0,2'b00,2'b10,0,0,3'd0,2'd0,
                     2'b00,2'b00,3'd0,0,1,0));
    fetch(16'h3680);
    step("ld_dec", Z);
    step("ld_rd", mk(0,1,0,0,2'b00,2'b10,0,0,3'd0,2'd0,
                     2'b00,2'b00,3'd0,0,0,0));
    step("ld_wb", mk(0,0,0,1,2'b00,2'b00,0,0,3'b001,2'd0,
                     2'b00,2'b00,3'd0,0,0,0));
    fetch(16'h6280);
    step("str_dec", Z);
    step("str_wr", mk(0,0,0,0,2'b00,2'b01,0,0,3'd0,2'd0,
                      2'b00,2'b00,3'd0,0,1,0));
    fetch(16'h5680);
    step("ldr_dec", Z);
    step("ldr_rd", mk(0,1,0,0,2'b00,2'b01,0,0,3'd0,2'd0,
                      2'b00,2'b00,3'd0,0,0,0));
    step("ldr_wb", mk(0,0,0,1,2'b00,2'b00,0,0,3'b001,2'd0,
                      2'b00,2'b00,3'd0,0,0,0));

    // MOV, JMP, JAL, JR
    fetch(16'h7280);
    step("mov_dec", mk(0,0,0,1,2'b00,2'b00,0,0,3'b010,2'd0,
                       2'b00,2'b00,3'd0,0,0,0));
    fetch(16'h8020);
    step("jmp_dec", mk(1,0,0,0,2'b00,2'b00,1,0,3'd0,2'd0,
                       2'b00,2'b00,3'd0,0,0,0));
    fetch(16'hD020);
    step("jal_dec", mk(1,0,0,1,2'b00,2'b00,1,0,3'b100,2'b01,
                       2'b00,2'b00,3'd0,0,0,0));
    fetch(16'hE1C0);
    step("jr_dec", mk(1,0,0,0,2'b00,2'b00,0,1,3'd0,2'd0,
                      2'b00,2'b00,3'd0,0,0,0));

    // reset in the middle of a store
    fetch(16'h4280);
    step("st2_dec", Z);
`ifdef MIPS8_MEM_WAIT_EN
    mem_ready = 1'b0;
    step("st2_wait", mk(0,0,0,0,2'b00,2'b10,0,0,3'd0,2'd0,
                        2'b00,2'b00,3'd0,0,1,0));
`endif
    chk("st2_wr", got, mk(0,0,0,0,2'b00,2'b10,0,0,3'd0,2'd0,
                          2'b00,2'b00,3'd0,0,1,0));
    rst = 1'b0;
    #1;
    chk("st2_rst", got, Z);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;

    // HALT then recover through reset
    fetch(16'hF000);
    step("halt_dec", Z);
    for (int i = 0; i < 3; i++)
      step("halted", mk(0,0,0,0,2'b00,2'b00,0,0,3'd0,2'd0,
                        2'b00,2'b00,3'd0,0,0,1));
    rst = 1'b0;
    #1;
    chk("halt_rst", got, Z);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    step("restart_fh", FH);
    step("restart_fl", FL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
